onchip_ram_dp: RTL and testbench

- Parametrised, single-clock, true-dual-port on-chip RAM with two independent Avalon-MM slaves (s1, s2).
- Successor to the fixed 4096x32 single-port, unregistered-output memory.
- Adds: configurable width, depth and read latency; readdatavalid pipeline; waitrequest; byte-lane writes on both ports; deterministic cross-port collision rules; optional post-reset zero-fill.
- Sits on the Nios system interconnect as program/data RAM. Port s2 is usable by a DMA or camera frame writer.

---
 rtl/onchip_ram_pkg.sv | 18 +
 rtl/onchip_ram_dp_if.sv | 25 ++
 rtl/onchip_ram_dp_core.sv | 71 +++++++
 rtl/onchip_ram_dp.sv | 178 +++++++++++++++++
 tb/tb_onchip_ram_dp.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/onchip_ram_pkg.sv
// Shared types and constants for the dual-port on-chip RAM.
// The parity option is selected by the ONCHIP_RAM_PARITY_EN macro in the RAM sources.
package onchip_ram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        READY = 2'd2
    } clr_state_e;

    localparam int MIN_LAT = 1;
    localparam int MAX_LAT = 2;

    function automatic int lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/onchip_ram_dp_if.sv
// Avalon-MM slave bundle for one port of onchip_ram_dp.
interface onchip_ram_dp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0]   address;
    logic                chipselect;
    logic                read;
    logic                write;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;
    logic                waitrequest;

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/onchip_ram_dp_core.sv
// Behavioural dual-port lane-enabled array with a per-port read pipeline.
// Slot width carries the optional parity bit (ONCHIP_RAM_PARITY_EN), chosen by the top.
module onchip_ram_dp_core #(
    parameter int ADDR_W = 12,
    parameter int LANES  = 4,
    parameter int SLOT_W = 8,
    parameter int LAT    = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clken,
    input  logic [ADDR_W-1:0]         addr   [2],
    input  logic [LANES-1:0]          be     [2],
    input  logic [LANES*SLOT_W-1:0]   wdata  [2],
    input  logic [1:0]                we,
    input  logic [1:0]                re,
    output logic [LANES*SLOT_W-1:0]   rdata  [2],
    output logic [1:0]                rvalid
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int MEM_W = LANES * SLOT_W;

    logic [MEM_W-1:0] mem   [DEPTH];
    logic [MEM_W-1:0] stg_d [2][LAT];
    logic [LAT-1:0]   stg_v [2];

    // Port 0 is applied last so it wins any lane both ports touch.
    always_ff @(posedge clk) begin
        if (clken) begin
            for (int p = 1; p >= 0; p--) begin
                if (we[p]) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (be[p][i])
                            mem[addr[p]][i*SLOT_W +: SLOT_W] <= wdata[p][i*SLOT_W +: SLOT_W];
                    end
                end
            end
        end
    end

    // Data registers only load behind a valid bit, so the output holds between returns.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < 2; p++) begin
                stg_v[p] <= '0;
                for (int s = 0; s < LAT; s++)
                    stg_d[p][s] <= '0;
            end
        end else if (clken) begin
            for (int p = 0; p < 2; p++) begin
                stg_v[p][0] <= re[p];
                if (re[p])
                    stg_d[p][0] <= mem[addr[p]];
                for (int s = 1; s < LAT; s++) begin
                    stg_v[p][s] <= stg_v[p][s-1];
                    if (stg_v[p][s-1])
                        stg_d[p][s] <= stg_d[p][s-1];
                end
            end
        end
    end

    always_comb begin
        rvalid = '0;
        for (int p = 0; p < 2; p++) begin
            rdata[p]  = stg_d[p][LAT-1];
            rvalid[p] = stg_v[p][LAT-1] & clken;
        end
    end

endmodule

// File: rtl/onchip_ram_dp.sv
// True-dual-port on-chip RAM: post-reset zero-fill, acceptance and cross-port write merge.
// Define ONCHIP_RAM_PARITY_EN to store per-lane even parity and expose parity_err.
//
// state | meaning
// IDLE  | transient after an illegal encoding; picks CLEAR or READY
// CLEAR | zero-filling word cnt, all requests held off
// READY | normal traffic
module onchip_ram_dp
    import onchip_ram_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 12,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clken,
    output logic clear_busy,
`ifdef ONCHIP_RAM_PARITY_EN
    output logic parity_err,
`endif
    onchip_ram_dp_if.slave s1,
    onchip_ram_dp_if.slave s2
);
    localparam int LANES = lanes(DATA_W);
`ifdef ONCHIP_RAM_PARITY_EN
    localparam int SLOT_W = 9;
`else
    localparam int SLOT_W = 8;
`endif
    localparam int MEM_W = LANES * SLOT_W;
    localparam int LAT   = (READ_LATENCY < MIN_LAT) ? MIN_LAT :
                           (READ_LATENCY > MAX_LAT) ? MAX_LAT : READ_LATENCY;

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_CLEAR = CLEAR;
    localparam logic [1:0] S_READY = READY;
    localparam logic [1:0] S_INIT  = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
    localparam logic [ADDR_W-1:0] LAST = '1;

    logic [1:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic              wait_any;
    logic              wr1, wr2, rd1, rd2, collide;

    logic [ADDR_W-1:0] c_addr  [2];
    logic [LANES-1:0]  c_be    [2];
    logic [MEM_W-1:0]  c_wdata [2];
    logic [1:0]        c_we, c_re;
    logic [MEM_W-1:0]  c_rdata [2];
    logic [1:0]        c_rvalid;
    logic [DATA_W-1:0] rd_data [2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_INIT;
            cnt   <= '0;
        end else if (clken) begin
            case (state)
                S_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST)
                        state <= S_READY;
                end
                S_READY: state <= S_READY;
                S_IDLE:  state <= S_INIT;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign clear_busy     = (state == S_CLEAR);
    assign wait_any       = clear_busy | ~clken;
    assign s1.waitrequest = wait_any;
    assign s2.waitrequest = wait_any;

    // A simultaneous read+write on one port is a write only.
    assign wr1     = s1.chipselect & s1.write & ~wait_any;
    assign wr2     = s2.chipselect & s2.write & ~wait_any;
    assign rd1     = s1.chipselect & s1.read & ~s1.write & ~wait_any;
    assign rd2     = s2.chipselect & s2.read & ~s2.write & ~wait_any;
    assign collide = wr1 & wr2 & (s1.address == s2.address);

    function automatic logic [MEM_W-1:0] to_slots(input logic [DATA_W-1:0] d);
        logic [MEM_W-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            r[i*SLOT_W +: 8] = d[i*8 +: 8];
`ifdef ONCHIP_RAM_PARITY_EN
            r[i*SLOT_W + 8] = ^d[i*8 +: 8];
`endif
        end
        return r;
    endfunction

    // Colliding writes are folded into port 0: s1 lanes first, s2 fills the rest.
    always_comb begin
        c_addr[0]  = s1.address;
        c_be[0]    = s1.byteenable;
        c_wdata[0] = to_slots(s1.writedata);
        c_addr[1]  = s2.address;
        c_be[1]    = s2.byteenable;
        c_wdata[1] = to_slots(s2.writedata);
        c_we       = {wr2 & ~collide, wr1};
        c_re       = {rd2, rd1};
        if (clear_busy) begin
            c_addr[0]  = cnt;
            c_be[0]    = '1;
            c_wdata[0] = '0;
            c_we[0]    = clken;
            c_re       = '0;
        end else if (collide) begin
            c_be[0] = s1.byteenable | s2.byteenable;
            for (int i = 0; i < LANES; i++) begin
                if (!s1.byteenable[i])
                    c_wdata[0][i*SLOT_W +: SLOT_W] = c_wdata[1][i*SLOT_W +: SLOT_W];
            end
        end
    end

    onchip_ram_dp_core #(
        .ADDR_W (ADDR_W),
        .LANES  (LANES),
        .SLOT_W (SLOT_W),
        .LAT    (LAT)
    ) u_core (
        .clk    (clk),
        .reset_n(reset_n),
        .clken  (clken),
        .addr   (c_addr),
        .be     (c_be),
        .wdata  (c_wdata),
        .we     (c_we),
        .re     (c_re),
        .rdata  (c_rdata),
        .rvalid (c_rvalid)
    );

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = '0;
            for (int i = 0; i < LANES; i++)
                rd_data[p][i*8 +: 8] = c_rdata[p][i*SLOT_W +: 8];
        end
    end

    assign s1.readdata      = rd_data[0];
    assign s2.readdata      = rd_data[1];
    assign s1.readdatavalid = c_rvalid[0];
    assign s2.readdatavalid = c_rvalid[1];

`ifdef ONCHIP_RAM_PARITY_EN
    logic       perr_q;
    logic [1:0] hit;

    always_comb begin
        hit = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < LANES; i++) begin
                if (^c_rdata[p][i*SLOT_W +: SLOT_W])
                    hit[p] = c_rvalid[p];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            perr_q <= 1'b0;
        else if (clken && (|hit))
            perr_q <= 1'b1;
    end

    // Flags in the same cycle as the offending readdatavalid, then sticks.
    assign parity_err = perr_q | (|hit);
`endif

endmodule

// File: tb/tb_onchip_ram_dp.sv
// Directed and randomized self-checking bench for onchip_ram_dp (DATA_W=32, ADDR_W=4, READ_LATENCY=2).
// Build with ONCHIP_RAM_PARITY_EN to also exercise the parity path.
module tb_onchip_ram_dp;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int LAT   = 2;
    localparam int DEPTH = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic clken   = 1'b1;
    logic clear_busy;
`ifdef ONCHIP_RAM_PARITY_EN
    logic parity_err;
`endif

    onchip_ram_dp_if #(.DATA_W(DW), .ADDR_W(AW)) s1_if ();
    onchip_ram_dp_if #(.DATA_W(DW), .ADDR_W(AW)) s2_if ();

    onchip_ram_dp #(
        .DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(LAT), .CLEAR_ON_RESET(1)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clken     (clken),
        .clear_busy(clear_busy),
`ifdef ONCHIP_RAM_PARITY_EN
        .parity_err(parity_err),
`endif
        .s1        (s1_if),
        .s2        (s2_if)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] data;
        int          rem;
    } pend_t;

    pend_t       pq [2][$];
    logic [31:0] model [DEPTH];
    logic [31:0] lastd [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s1_if.chipselect = 0; s1_if.read = 0; s1_if.write = 0;
        s1_if.byteenable = 0; s1_if.writedata = 0; s1_if.address = 0;
        s2_if.chipselect = 0; s2_if.read = 0; s2_if.write = 0;
        s2_if.byteenable = 0; s2_if.writedata = 0; s2_if.address = 0;
    endtask

    task automatic set_wr(input int port, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        if (port == 1) begin
            s1_if.chipselect = 1; s1_if.write = 1; s1_if.address = a;
            s1_if.writedata = d; s1_if.byteenable = be;
        end else begin
            s2_if.chipselect = 1; s2_if.write = 1; s2_if.address = a;
            s2_if.writedata = d; s2_if.byteenable = be;
        end
    endtask

    task automatic set_rd(input int port, input logic [3:0] a);
        if (port == 1) begin
            s1_if.chipselect = 1; s1_if.read = 1; s1_if.address = a;
        end else begin
            s2_if.chipselect = 1; s2_if.read = 1; s2_if.address = a;
        end
    endtask

    task automatic wr(input int port, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        set_wr(port, a, d, be);
        tick();
        idle();
    endtask

    task automatic wait_valid(input int port, output logic [31:0] d);
        int   n;
        logic v;
        n = 1;
        v = (port == 1) ? s1_if.readdatavalid : s2_if.readdatavalid;
        while (!v && n < 10) begin
            tick();
            n++;
            v = (port == 1) ? s1_if.readdatavalid : s2_if.readdatavalid;
        end
        chk("rd_latency", n, LAT);
        d = (port == 1) ? s1_if.readdata : s2_if.readdata;
    endtask

    task automatic rd(input int port, input logic [3:0] a, output logic [31:0] d);
        set_rd(port, a);
        tick();
        idle();
        wait_valid(port, d);
    endtask

    task automatic release_and_count(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        reset_n = 1;
        while (clear_busy && n < 100) begin
            tick();
            n++;
        end
        chk(tag, n, DEPTH);
        chk({tag, "_wait"}, {s1_if.waitrequest, s2_if.waitrequest}, 2'b00);
    endtask

    task automatic burst(input int drop, input string tag);
        int issued;
        int got;
        int base;
        issued = 0;
        got    = 0;
        base   = (drop < 0) ? LAT : LAT + 1;
        for (int k = 0; k < 10; k++) begin
            clken = (k != drop);
            if (issued < 3) set_rd(1, 4'(issued));
            else            idle();
            #1;
            if (s1_if.readdatavalid) begin
                chk({tag, "_cyc"}, k, base + got);
                chk({tag, "_data"}, s1_if.readdata, 32'h100 + got);
                got++;
            end
            if (issued < 3 && !s1_if.waitrequest) issued++;
            tick();
            idle();
        end
        clken = 1;
        chk({tag, "_count"}, got, 3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [31:0] acc;
        logic [1:0]  cs, r, w;
        logic [3:0]  a  [2];
        logic [3:0]  be [2];
        logic [31:0] wd [2];
        logic        exp_v, obs_v, obs_w;
        logic [31:0] obs_d;

        idle();
        repeat (2) tick();
        chk("rst_busy", clear_busy, 1);
        chk("rst_wait", {s1_if.waitrequest, s2_if.waitrequest}, 2'b11);
        chk("rst_valid", {s1_if.readdatavalid, s2_if.readdatavalid}, 2'b00);
        release_and_count("clear_len");

        // reset reasserted partway through a clear restarts the full fill
        reset_n = 0;
        tick();
        @(negedge clk);
        reset_n = 1;
        repeat (7) tick();
        reset_n = 0;
        tick();
        chk("midclr_busy", clear_busy, 1);
        release_and_count("midclr_len");

        for (int i = 0; i < DEPTH; i++)
            wr(2, 4'(i), {8'hA5, 8'(i), 8'h5A, 8'(i + 1)}, 4'hF);
        rd(1, 4'd3, d);
        chk("fill_rd", d, 32'hA5035A04);

        reset_n = 0;
        #1;
        chk("rst_rdata", {s1_if.readdata, s2_if.readdata}, 64'h0);
        chk("rst_valid2", {s1_if.readdatavalid, s2_if.readdatavalid}, 2'b00);
        chk("rst_busy2", clear_busy, 1);
        tick();
        release_and_count("clear_len2");
        acc = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rd((i % 2) + 1, 4'(i), d);
            acc |= d;
        end
        chk("zero_fill", acc, 32'h0);

        wr(1, 4'd3, 32'hAABBCCDD, 4'b1111);
        wr(1, 4'd3, 32'h11223344, 4'b0101);
        rd(2, 4'd3, d);
        chk("byte_lane", d, 32'hAA22CC44);
        wr(2, 4'd3, 32'hFFFFFFFF, 4'b0000);
        rd(1, 4'd3, d);
        chk("be_zero", d, 32'hAA22CC44);

        for (int i = 0; i < 3; i++)
            wr(1, 4'(i), 32'h100 + i, 4'hF);
        burst(-1, "burst");
        burst(1, "burst_clken");

        set_wr(1, 4'd5, 32'h12345678, 4'b0011);
        set_wr(2, 4'd5, 32'hFFFFFFFF, 4'b1111);
        tick();
        idle();
        rd(1, 4'd5, d);
        chk("coll_ww", d, 32'hFFFF5678);
        set_wr(1, 4'd7, 32'hAAAAAAAA, 4'b1100);
        set_wr(2, 4'd7, 32'h55555555, 4'b0110);
        tick();
        idle();
        rd(2, 4'd7, d);
        chk("coll_ww_lanes", d, 32'hAAAA5500);
        set_wr(1, 4'd6, 32'hDEADBEEF, 4'hF);
        set_rd(2, 4'd6);
        tick();
        idle();
        wait_valid(2, d);
        chk("coll_rw_old", d, 32'h0);
        rd(2, 4'd6, d);
        chk("coll_rw_new", d, 32'hDEADBEEF);

`ifdef ONCHIP_RAM_PARITY_EN
        wr(1, 4'd2, 32'h0F0F0F0F, 4'hF);
        rd(1, 4'd2, d);
        chk("par_clean", parity_err, 0);
        u_dut.u_core.mem[2][0] = ~u_dut.u_core.mem[2][0];
        rd(1, 4'd2, d);
        chk("par_rise", parity_err, 1);
        repeat (3) tick();
        chk("par_sticky", parity_err, 1);
        reset_n = 0;
        #1;
        chk("par_reset", parity_err, 0);
        tick();
        release_and_count("par_clear");
`endif

        // randomized traffic against a transaction-level model
        reset_n = 0;
        tick();
        release_and_count("clear_len3");
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        lastd[0] = '0;
        lastd[1] = '0;
        for (int c = 0; c < 400; c++) begin
            clken = ($urandom_range(7) != 0);
            for (int p = 0; p < 2; p++) begin
                cs[p] = ($urandom_range(3) != 0);
                r[p]  = 1'($urandom_range(1));
                w[p]  = ($urandom_range(2) == 0);
                a[p]  = 4'($urandom_range(3));
                be[p] = 4'($urandom_range(15));
                wd[p] = $urandom;
            end
            s1_if.chipselect = cs[0]; s1_if.read = r[0]; s1_if.write = w[0];
            s1_if.address = a[0]; s1_if.byteenable = be[0]; s1_if.writedata = wd[0];
            s2_if.chipselect = cs[1]; s2_if.read = r[1]; s2_if.write = w[1];
            s2_if.address = a[1]; s2_if.byteenable = be[1]; s2_if.writedata = wd[1];
            #1;
            for (int p = 0; p < 2; p++) begin
                obs_v = (p == 0) ? s1_if.readdatavalid : s2_if.readdatavalid;
                obs_d = (p == 0) ? s1_if.readdata : s2_if.readdata;
                obs_w = (p == 0) ? s1_if.waitrequest : s2_if.waitrequest;
                exp_v = clken && (pq[p].size() > 0) && (pq[p][0].rem == 0);
                chk("rnd_valid", obs_v, exp_v);
                chk("rnd_wait", obs_w, !clken);
                if (exp_v) begin
                    chk("rnd_data", obs_d, pq[p][0].data);
                    lastd[p] = pq[p][0].data;
                    pq[p].delete(0);
                end else if (clken) begin
                    chk("rnd_hold", obs_d, lastd[p]);
                end
            end
            if (clken) begin
                for (int p = 0; p < 2; p++) begin
                    for (int j = 0; j < pq[p].size(); j++) pq[p][j].rem--;
                    if (cs[p] && r[p] && !w[p])
                        pq[p].push_back('{data: model[a[p]], rem: LAT - 1});
                end
                for (int p = 1; p >= 0; p--) begin
                    if (cs[p] && w[p]) begin
                        for (int l = 0; l < 4; l++)
                            if (be[p][l]) model[a[p]][l*8 +: 8] = wd[p][l*8 +: 8];
                    end
                end
            end
            tick();
        end
        clken = 1;
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
